bht_update_queue: RTL and testbench

- Writer-side companion to the branch history table (BHT).
- Records each prediction issued at fetch in program order.
- Matches each prediction, in order, with its resolved outcome from execute.
- Drives the BHT update port (load, w_idx, taken, correct), raises a one-cycle flush on mispredict, and keeps branch/mispredict statistics.

---
 rtl/bht_update_queue.sv | 169 ++++++++++++++++
 tb/tb_bht_update_queue.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bht_update_queue.sv
// -----------------------------------------------------------------------------
// bht_update_queue
// Writer-side companion to the branch history table. Predictions issued at
// fetch are queued in program order. Each one is paired, oldest first, with
// its resolved outcome from execute. The block then drives the BHT update
// port, pulses a flush on a mispredict, and keeps branch/mispredict counts.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   push_valid/idx/pred      prediction issued at fetch
//   push_ready               queue not full
//   resolve_valid/taken      outcome for the oldest in-flight branch
//   resolve_ready            queue not empty
//   bht_load/w_idx/taken/correct  registered BHT update, one cycle after resolve
//   flush                    one-cycle mispredict pulse, aligned with bht_load
//   occupancy                entries currently held
//   branch_cnt, mispred_cnt  wrapping statistics counters
//   underflow_err            sticky: resolve attempted while empty
// -----------------------------------------------------------------------------
module bht_update_queue #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8,
   parameter int CNT_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_valid,
   input  logic [WIDTH-1:0]         push_idx,
   input  logic                     push_pred,
   output logic                     push_ready,
   input  logic                     resolve_valid,
   input  logic                     resolve_taken,
   output logic                     resolve_ready,
   output logic                     bht_load,
   output logic [WIDTH-1:0]         bht_w_idx,
   output logic                     bht_taken,
   output logic                     bht_correct,
   output logic                     flush,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic [CNT_W-1:0]         branch_cnt,
   output logic [CNT_W-1:0]         mispred_cnt,
   output logic                     underflow_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] L_FULL = CW'(DEPTH);

   // Storage and pointers
   logic [WIDTH:0]     r_mem [DEPTH];
   logic [PW-1:0]      r_head;
   logic [PW-1:0]      r_tail;
   logic [CW-1:0]      r_count;

   // Registered outputs
   logic               r_load;
   logic [WIDTH-1:0]   r_w_idx;
   logic               r_taken;
   logic               r_correct;
   logic               r_flush;
   logic [CNT_W-1:0]   r_branch_cnt;
   logic [CNT_W-1:0]   r_mispred_cnt;
   logic               r_underflow;

   // Combinational handshake and next-state signals
   logic               w_push_ready;
   logic               w_resolve_ready;
   logic               w_push_acc;
   logic               w_res_acc;
   logic [WIDTH:0]     w_head_ent;
   logic               w_correct;
   logic               w_mispred;
   logic [PW-1:0]      w_head_nxt;
   logic [PW-1:0]      w_tail_nxt;
   logic [CW-1:0]      w_count_nxt;

   assign w_push_ready    = (r_count != L_FULL);
   assign w_resolve_ready = (r_count != {CW{1'b0}});
   assign w_push_acc      = push_valid && w_push_ready;
   assign w_res_acc       = resolve_valid && w_resolve_ready;
   assign w_head_ent      = r_mem[r_head];
   assign w_correct       = (w_head_ent[0] == resolve_taken);
   assign w_mispred       = w_res_acc && !w_correct;

   // Pointer/count next state; a mispredict squashes everything in flight,
   // including a push arriving in the same cycle.
   always_comb begin
      w_head_nxt  = r_head;
      w_tail_nxt  = r_tail;
      w_count_nxt = r_count;
      if (w_mispred) begin
         w_head_nxt  = r_tail;
         w_count_nxt = {CW{1'b0}};
      end else begin
         case ({w_push_acc, w_res_acc})
            2'b10: begin
               w_tail_nxt  = r_tail + PW'(1);
               w_count_nxt = r_count + CW'(1);
            end
            2'b01: begin
               w_head_nxt  = r_head + PW'(1);
               w_count_nxt = r_count - CW'(1);
            end
            2'b11: begin
               w_tail_nxt  = r_tail + PW'(1);
               w_head_nxt  = r_head + PW'(1);
            end
            default: begin
               w_count_nxt = r_count;
            end
         endcase
      end
   end

   // Entry storage; squashed pushes are never written
   always_ff @(posedge clk) begin
      if (!rst && w_push_acc && !w_mispred) begin
         r_mem[r_tail] <= {push_idx, push_pred};
      end
   end

   // Pointers, count, BHT update port, flush, statistics
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head        <= {PW{1'b0}};
         r_tail        <= {PW{1'b0}};
         r_count       <= {CW{1'b0}};
         r_load        <= 1'b0;
         r_w_idx       <= {WIDTH{1'b0}};
         r_taken       <= 1'b0;
         r_correct     <= 1'b0;
         r_flush       <= 1'b0;
         r_branch_cnt  <= {CNT_W{1'b0}};
         r_mispred_cnt <= {CNT_W{1'b0}};
         r_underflow   <= 1'b0;
      end else begin
         r_head  <= w_head_nxt;
         r_tail  <= w_tail_nxt;
         r_count <= w_count_nxt;
         r_load  <= w_res_acc;
         r_flush <= w_mispred;
         if (w_res_acc) begin
            r_w_idx      <= w_head_ent[WIDTH:1];
            r_taken      <= w_head_ent[0];
            r_correct    <= w_correct;
            r_branch_cnt <= r_branch_cnt + CNT_W'(1);
         end
         if (w_mispred) begin
            r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
         end
         if (resolve_valid && !w_resolve_ready) begin
            r_underflow <= 1'b1;
         end
      end
   end

   assign push_ready    = w_push_ready;
   assign resolve_ready = w_resolve_ready;
   assign bht_load      = r_load;
   assign bht_w_idx     = r_w_idx;
   assign bht_taken     = r_taken;
   assign bht_correct   = r_correct;
   assign flush         = r_flush;
   assign occupancy     = r_count;
   assign branch_cnt    = r_branch_cnt;
   assign mispred_cnt   = r_mispred_cnt;
   assign underflow_err = r_underflow;

endmodule

// File: tb/tb_bht_update_queue.sv
// -----------------------------------------------------------------------------
// tb_bht_update_queue
// Directed bench for bht_update_queue: each scenario task drives stimulus and
// compares outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_bht_update_queue;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         push_valid = 1'b0;
   logic [9:0]   push_idx = 10'd0;
   logic         push_pred = 1'b0;
   logic         push_ready;
   logic         resolve_valid = 1'b0;
   logic         resolve_taken = 1'b0;
   logic         resolve_ready;
   logic         bht_load;
   logic [9:0]   bht_w_idx;
   logic         bht_taken;
   logic         bht_correct;
   logic         flush;
   logic [3:0]   occupancy;
   logic [31:0]  branch_cnt;
   logic [31:0]  mispred_cnt;
   logic         underflow_err;

   int checks = 0;
   int failures = 0;

   bht_update_queue #(.WIDTH(10), .DEPTH(8), .CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .push_valid(push_valid), .push_idx(push_idx), .push_pred(push_pred),
      .push_ready(push_ready),
      .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
      .resolve_ready(resolve_ready),
      .bht_load(bht_load), .bht_w_idx(bht_w_idx), .bht_taken(bht_taken),
      .bht_correct(bht_correct), .flush(flush), .occupancy(occupancy),
      .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt),
      .underflow_err(underflow_err)
   );

   always #5 clk = ~clk;

   // Advance one clock; outputs are then sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      push_valid = 1'b0;
      resolve_valid = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic push1(input logic [9:0] idx, input logic pred);
      push_valid = 1'b1; push_idx = idx; push_pred = pred;
      step();
      idle();
   endtask

   task automatic resolve1(input logic taken);
      resolve_valid = 1'b1; resolve_taken = taken;
      step();
      idle();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (bht_load !== 1'b0) begin failures++; $display("FAIL reset_load: got %0b expected 0", bht_load); end
      checks++; if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush: got %0b expected 0", flush); end
      checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
      checks++; if (push_ready !== 1'b1) begin failures++; $display("FAIL reset_push_ready: got %0b expected 1", push_ready); end
      checks++; if (resolve_ready !== 1'b0) begin failures++; $display("FAIL reset_resolve_ready: got %0b expected 0", resolve_ready); end
      checks++; if (branch_cnt !== 32'd0) begin failures++; $display("FAIL reset_branch_cnt: got %0d expected 0", branch_cnt); end
      checks++; if (underflow_err !== 1'b0) begin failures++; $display("FAIL reset_underflow: got %0b expected 0", underflow_err); end
   endtask

   task automatic test_basic_hit();
      do_reset();
      push1(10'h005, 1'b1);
      checks++; if (occupancy !== 4'd1) begin failures++; $display("FAIL hit_occ: got %0d expected 1", occupancy); end
      checks++; if (bht_load !== 1'b0) begin failures++; $display("FAIL hit_noload_on_push: got %0b expected 0", bht_load); end
      resolve1(1'b1);
      checks++; if (bht_load !== 1'b1) begin failures++; $display("FAIL hit_load: got %0b expected 1", bht_load); end
      checks++; if (bht_w_idx !== 10'h005) begin failures++; $display("FAIL hit_idx: got %0h expected 5", bht_w_idx); end
      checks++; if (bht_taken !== 1'b1) begin failures++; $display("FAIL hit_taken: got %0b expected 1", bht_taken); end
      checks++; if (bht_correct !== 1'b1) begin failures++; $display("FAIL hit_correct: got %0b expected 1", bht_correct); end
      checks++; if (flush !== 1'b0) begin failures++; $display("FAIL hit_flush: got %0b expected 0", flush); end
      checks++; if (branch_cnt !== 32'd1) begin failures++; $display("FAIL hit_branch_cnt: got %0d expected 1", branch_cnt); end
      checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL hit_occ_after: got %0d expected 0", occupancy); end
      step();
      checks++; if (bht_load !== 1'b0) begin failures++; $display("FAIL hit_load_pulse: got %0b expected 0", bht_load); end
      checks++; if (bht_w_idx !== 10'h005) begin failures++; $display("FAIL hit_idx_hold: got %0h expected 5", bht_w_idx); end
   endtask

   task automatic test_mispredict();
      do_reset();
      push1(10'h001, 1'b0);
      push1(10'h002, 1'b0);
      push1(10'h003, 1'b0);
      checks++; if (occupancy !== 4'd3) begin failures++; $display("FAIL mis_occ_pre: got %0d expected 3", occupancy); end
      resolve1(1'b1);
      checks++; if (bht_load !== 1'b1) begin failures++; $display("FAIL mis_load: got %0b expected 1", bht_load); end
      checks++; if (bht_w_idx !== 10'h001) begin failures++; $display("FAIL mis_idx: got %0h expected 1", bht_w_idx); end
      checks++; if (bht_taken !== 1'b0) begin failures++; $display("FAIL mis_taken: got %0b expected 0", bht_taken); end
      checks++; if (bht_correct !== 1'b0) begin failures++; $display("FAIL mis_correct: got %0b expected 0", bht_correct); end
      checks++; if (flush !== 1'b1) begin failures++; $display("FAIL mis_flush: got %0b expected 1", flush); end
      checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL mis_occ: got %0d expected 0", occupancy); end
      checks++; if (mispred_cnt !== 32'd1) begin failures++; $display("FAIL mis_cnt: got %0d expected 1", mispred_cnt); end
      checks++; if (underflow_err !== 1'b0) begin failures++; $display("FAIL mis_underflow_pre: got %0b expected 0", underflow_err); end
      resolve1(1'b0);
      checks++; if (underflow_err !== 1'b1) begin failures++; $display("FAIL mis_underflow: got %0b expected 1", underflow_err); end
      checks++; if (bht_load !== 1'b0) begin failures++; $display("FAIL mis_underflow_noload: got %0b expected 0", bht_load); end
      checks++; if (flush !== 1'b0) begin failures++; $display("FAIL mis_flush_pulse: got %0b expected 0", flush); end
      checks++; if (branch_cnt !== 32'd1) begin failures++; $display("FAIL mis_branch_cnt: got %0d expected 1", branch_cnt); end
      step();
      checks++; if (underflow_err !== 1'b1) begin failures++; $display("FAIL mis_underflow_sticky: got %0b expected 1", underflow_err); end
   endtask

   task automatic test_fill_wrap();
      logic [9:0] exp_idx [11];
      logic       exp_pred [11];
      do_reset();
      for (int i = 0; i < 8; i++) begin
         push1(10'h010 + 10'(i), 1'(i % 2));
      end
      checks++; if (push_ready !== 1'b0) begin failures++; $display("FAIL fill_push_ready: got %0b expected 0", push_ready); end
      checks++; if (occupancy !== 4'd8) begin failures++; $display("FAIL fill_occ: got %0d expected 8", occupancy); end
      push1(10'h3FF, 1'b1);
      checks++; if (occupancy !== 4'd8) begin failures++; $display("FAIL fill_ninth_ignored: got %0d expected 8", occupancy); end
      for (int i = 0; i < 8; i++) begin
         exp_idx[i] = 10'h010 + 10'(i);
         exp_pred[i] = 1'(i % 2);
      end
      for (int i = 8; i < 11; i++) begin
         exp_idx[i] = 10'h020 + 10'(i - 8);
         exp_pred[i] = 1'b1;
      end
      for (int i = 0; i < 3; i++) begin
         resolve1(exp_pred[i]);
         checks++; if (bht_w_idx !== exp_idx[i]) begin failures++; $display("FAIL wrap_idx_%0d: got %0h expected %0h", i, bht_w_idx, exp_idx[i]); end
      end
      for (int i = 8; i < 11; i++) begin
         push1(exp_idx[i], 1'b1);
      end
      checks++; if (occupancy !== 4'd8) begin failures++; $display("FAIL wrap_occ_refill: got %0d expected 8", occupancy); end
      for (int i = 3; i < 11; i++) begin
         resolve1(exp_pred[i]);
         checks++; if (bht_w_idx !== exp_idx[i] || bht_load !== 1'b1 || bht_correct !== 1'b1) begin
            failures++; $display("FAIL wrap_order_%0d: got idx=%0h load=%0b correct=%0b expected idx=%0h load=1 correct=1", i, bht_w_idx, bht_load, bht_correct, exp_idx[i]);
         end
      end
      checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL wrap_occ_end: got %0d expected 0", occupancy); end
      checks++; if (branch_cnt !== 32'd11) begin failures++; $display("FAIL wrap_branch_cnt: got %0d expected 11", branch_cnt); end
      checks++; if (mispred_cnt !== 32'd0) begin failures++; $display("FAIL wrap_mispred_cnt: got %0d expected 0", mispred_cnt); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         push1(10'h040 + 10'(i), 1'b1);
      end
      push_valid = 1'b1; push_idx = 10'h050; push_pred = 1'b0;
      resolve_valid = 1'b1; resolve_taken = 1'b1;
      step(); idle();
      checks++; if (occupancy !== 4'd4) begin failures++; $display("FAIL sim_occ: got %0d expected 4", occupancy); end
      checks++; if (bht_load !== 1'b1 || bht_w_idx !== 10'h040) begin failures++; $display("FAIL sim_update: got load=%0b idx=%0h expected load=1 idx=40", bht_load, bht_w_idx); end
      push_valid = 1'b1; push_idx = 10'h060; push_pred = 1'b1;
      resolve_valid = 1'b1; resolve_taken = 1'b0;
      step(); idle();
      checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL sim_mis_occ: got %0d expected 0", occupancy); end
      checks++; if (flush !== 1'b1 || bht_w_idx !== 10'h041 || bht_correct !== 1'b0) begin
         failures++; $display("FAIL sim_mis_update: got flush=%0b idx=%0h correct=%0b expected flush=1 idx=41 correct=0", flush, bht_w_idx, bht_correct);
      end
      push1(10'h070, 1'b0);
      resolve1(1'b0);
      checks++; if (bht_w_idx !== 10'h070 || bht_correct !== 1'b1) begin failures++; $display("FAIL sim_squashed_push: got idx=%0h correct=%0b expected idx=70 correct=1", bht_w_idx, bht_correct); end
   endtask

   task automatic test_empty_edge();
      do_reset();
      push_valid = 1'b1; push_idx = 10'h02A; push_pred = 1'b1;
      resolve_valid = 1'b1; resolve_taken = 1'b1;
      #1;
      checks++; if (resolve_ready !== 1'b0) begin failures++; $display("FAIL empty_resolve_ready: got %0b expected 0", resolve_ready); end
      step(); idle();
      checks++; if (occupancy !== 4'd1) begin failures++; $display("FAIL empty_occ: got %0d expected 1", occupancy); end
      checks++; if (bht_load !== 1'b0) begin failures++; $display("FAIL empty_noload: got %0b expected 0", bht_load); end
      checks++; if (branch_cnt !== 32'd0) begin failures++; $display("FAIL empty_branch_cnt: got %0d expected 0", branch_cnt); end
      checks++; if (underflow_err !== 1'b1) begin failures++; $display("FAIL empty_underflow: got %0b expected 1", underflow_err); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      resolve1(1'b0);
      push1(10'h011, 1'b0);
      push1(10'h012, 1'b0);
      resolve1(1'b1);
      checks++; if (flush !== 1'b1 || underflow_err !== 1'b1) begin failures++; $display("FAIL rmid_pre: got flush=%0b underflow=%0b expected 1 1", flush, underflow_err); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (flush !== 1'b0) begin failures++; $display("FAIL rmid_flush: got %0b expected 0", flush); end
      checks++; if (bht_load !== 1'b0) begin failures++; $display("FAIL rmid_load: got %0b expected 0", bht_load); end
      checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL rmid_occ: got %0d expected 0", occupancy); end
      checks++; if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin failures++; $display("FAIL rmid_counters: got %0d %0d expected 0 0", branch_cnt, mispred_cnt); end
      checks++; if (underflow_err !== 1'b0) begin failures++; $display("FAIL rmid_underflow: got %0b expected 0", underflow_err); end
      checks++; if (bht_w_idx !== 10'h000) begin failures++; $display("FAIL rmid_idx: got %0h expected 0", bht_w_idx); end
   endtask

   initial begin
      test_reset();
      test_basic_hit();
      test_mispredict();
      test_fill_wrap();
      test_simultaneous();
      test_empty_edge();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
